dap_cmd_dispatcher: RTL

DAP_CMD_DISPATCHER -- requirements
Module: dap_cmd_dispatcher

---
 rtl/dap_cmd_dispatcher.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dap_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// dap_cmd_dispatcher
//
// Accepts one command byte from the request stream, looks up which of four
// worker slots owns that command ID, echoes the command byte back on the
// response stream, then connects the selected worker straight through to both
// byte streams until the worker reports done. Unknown commands and workers
// that exceed the microsecond timeout produce a single 0xFF error byte.
//
// Ports
//   hclk, resetn          clock (rising edge) and async active-low reset
//   us_tick               one-cycle pulse per microsecond
//   dap_in_*              request byte stream (valid/ready/data)
//   dap_out_*             response byte stream (valid/data, no backpressure)
//   worker_en/start       per-slot enable (ECHO..FIN) and start (RUN only)
//   worker_in_*           request bytes broadcast to the slots, per-slot ready
//   worker_out_*          per-slot response bytes (slot n on bits 8n+7:8n)
//   worker_done           per-slot completion, only the selected bit is used
//   busy                  high whenever the dispatcher is not idle
//   err_pulse             one-cycle pulse on unknown command or timeout
// -----------------------------------------------------------------------------
module dap_cmd_dispatcher #(
  parameter logic [7:0]  CMD_ID0    = 8'h00,
  parameter logic [7:0]  CMD_ID1    = 8'h09,
  parameter logic [7:0]  CMD_ID2    = 8'h02,
  parameter logic [7:0]  CMD_ID3    = 8'h03,
  parameter logic [15:0] TIMEOUT_US = 16'd65535
) (
  input  logic        hclk,
  input  logic        resetn,
  input  logic        us_tick,
  input  logic        dap_in_tvalid,
  output logic        dap_in_tready,
  input  logic [7:0]  dap_in_tdata,
  output logic        dap_out_tvalid,
  output logic [7:0]  dap_out_tdata,
  output logic [3:0]  worker_en,
  output logic [3:0]  worker_start,
  output logic        worker_in_tvalid,
  output logic [7:0]  worker_in_tdata,
  input  logic [3:0]  worker_in_tready,
  input  logic [3:0]  worker_out_tvalid,
  input  logic [31:0] worker_out_tdata,
  input  logic [3:0]  worker_done,
  output logic        busy,
  output logic        err_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ECHO,
    S_RUN,
    S_FIN,
    S_ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  cmd;
  logic [1:0]  sel;
  logic [15:0] cnt;

  logic        match_hit;
  logic [1:0]  match_sel;
  logic [3:0]  sel_mask;
  logic        timeout;

  // Priority lookup: the lowest slot wins if two IDs are configured equal.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    match_hit = 1'b1;
    match_sel = 2'd0;
    if (dap_in_tdata == CMD_ID0)      match_sel = 2'd0;
    else if (dap_in_tdata == CMD_ID1) match_sel = 2'd1;
    else if (dap_in_tdata == CMD_ID2) match_sel = 2'd2;
    else if (dap_in_tdata == CMD_ID3) match_sel = 2'd3;
    else                              match_hit = 1'b0;
  end

  assign sel_mask = 4'b0001 << sel;
  assign timeout  = us_tick && (cnt == TIMEOUT_US);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cmd   <= '0;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && dap_in_tvalid) begin
        cmd <= dap_in_tdata;
        sel <= match_sel;
      end
      // Cleared in ECHO so the count is zero on the first RUN cycle.
      if (state == S_ECHO) begin
        cnt <= '0;
      end else if (state == S_RUN && us_tick && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_next       = state;
    dap_in_tready    = 1'b0;
    dap_out_tvalid   = 1'b0;
    dap_out_tdata    = 8'h00;
    worker_en        = 4'b0000;
    worker_start     = 4'b0000;
    worker_in_tvalid = 1'b0;
    worker_in_tdata  = 8'h00;
    err_pulse        = 1'b0;

    case (state)
      S_IDLE: begin
        // State is forced to IDLE during reset; gating with resetn keeps the
        // request stream stalled until reset is actually released.
        dap_in_tready = resetn;
        if (dap_in_tvalid) state_next = match_hit ? S_ECHO : S_ERR;
      end
      S_ECHO: begin
        dap_out_tvalid = 1'b1;
        dap_out_tdata  = cmd;
        worker_en      = sel_mask;
        state_next     = S_RUN;
      end
      S_RUN: begin
        worker_en        = sel_mask;
        worker_start     = sel_mask;
        worker_in_tvalid = dap_in_tvalid;
        worker_in_tdata  = dap_in_tdata;
        dap_in_tready    = worker_in_tready[sel];
        dap_out_tvalid   = worker_out_tvalid[sel];
        dap_out_tdata    = worker_out_tdata[{sel, 3'b000} +: 8];
        // Done is checked first so a worker finishing on the timeout tick
        // still completes normally.
        if (worker_done[sel]) state_next = S_FIN;
        else if (timeout)     state_next = S_ERR;
      end
      S_FIN: begin
        worker_en  = sel_mask;
        state_next = S_IDLE;
      end
      S_ERR: begin
        dap_out_tvalid = 1'b1;
        dap_out_tdata  = 8'hFF;
        err_pulse      = 1'b1;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
